// File: rtl/pwm_capture.sv
// rtl/pwm_capture.sv - PWM period/high-time capture with shape check, lock and stuck-line timeout
// Counts in CLK cycles between synchronised edges; results update once per completed period.

module pwm_capture #(
  parameter int CNT_BITS   = 8,
  parameter int EXP_PERIOD = 10,
  parameter int EXP_HIGH   = 7,
  parameter int TOL        = 0,
  parameter int LOCK_COUNT = 3
) (
  input  logic                CLK,
  input  logic                RST_N,
  input  logic                ENABLE,
  input  logic                PWM_IN,
  output logic [CNT_BITS-1:0] PERIOD,
  output logic [CNT_BITS-1:0] HIGH_TIME,
  output logic                VALID,
  output logic                MATCH,
  output logic                LOCKED,
  output logic                TIMEOUT,
  output logic                STUCK_LEVEL
);

  localparam int                  W1      = CNT_BITS + 1;
  localparam logic [CNT_BITS-1:0] CNT_MAX = '1;
  localparam logic [CNT_BITS-1:0] CNT_ONE = CNT_BITS'(1);
  localparam logic [W1-1:0]       EXP_P_W = W1'(EXP_PERIOD);
  localparam logic [W1-1:0]       EXP_H_W = W1'(EXP_HIGH);
  localparam logic [W1-1:0]       TOL_W   = W1'(TOL);
  localparam logic [3:0]          LOCK_W  = 4'(LOCK_COUNT);

  typedef enum logic [1:0] {ST_IDLE, ST_HIGH, ST_LOW} state_e;

  state_e              state_q, state_d;
  logic                sync1_q, sync1_d;
  logic                pwm_s_q, pwm_s_d;
  logic                pwm_d_q, pwm_d_d;
  logic [CNT_BITS-1:0] per_cnt_q, per_cnt_d;
  logic [CNT_BITS-1:0] hi_cnt_q, hi_cnt_d;
  logic [CNT_BITS-1:0] hi_hold_q, hi_hold_d;
  logic [CNT_BITS-1:0] period_q, period_d;
  logic [CNT_BITS-1:0] high_time_q, high_time_d;
  logic                valid_q, valid_d;
  logic                match_q, match_d;
  logic                locked_q, locked_d;
  logic                timeout_q, timeout_d;
  logic                stuck_q, stuck_d;
  logic [3:0]          streak_q, streak_d;

  logic                rise, fall, stuck_now, match_now;
  logic [CNT_BITS-1:0] per_inc, hi_inc;

  function automatic logic [W1-1:0] abs_diff(input logic [W1-1:0] a, input logic [W1-1:0] b);
    return (a >= b) ? (a - b) : (b - a);
  endfunction

  always_comb begin
    rise      = pwm_s_q & ~pwm_d_q;
    fall      = ~pwm_s_q & pwm_d_q;
    per_inc   = (per_cnt_q == CNT_MAX) ? CNT_MAX : per_cnt_q + CNT_ONE;
    hi_inc    = (hi_cnt_q == CNT_MAX) ? CNT_MAX : hi_cnt_q + CNT_ONE;
    // A same-cycle edge takes precedence over the saturation timeout.
    stuck_now = (per_cnt_q == CNT_MAX) && !rise && !fall;
    match_now = (abs_diff({1'b0, per_cnt_q}, EXP_P_W) <= TOL_W) &&
                (abs_diff({1'b0, hi_hold_q}, EXP_H_W) <= TOL_W);

    sync1_d     = PWM_IN;
    pwm_s_d     = sync1_q;
    pwm_d_d     = pwm_s_q;
    state_d     = state_q;
    per_cnt_d   = per_cnt_q;
    hi_cnt_d    = hi_cnt_q;
    hi_hold_d   = hi_hold_q;
    period_d    = period_q;
    high_time_d = high_time_q;
    valid_d     = 1'b0;
    match_d     = match_q;
    timeout_d   = 1'b0;
    stuck_d     = stuck_q;
    streak_d    = streak_q;
    locked_d    = locked_q | (streak_q == LOCK_W);

    if (valid_q) begin
      if (match_q) begin
        if (streak_q < LOCK_W) streak_d = streak_q + 4'd1;
      end else begin
        streak_d = 4'd0;
        locked_d = 1'b0;
      end
    end

    if (!ENABLE) begin
      state_d   = ST_IDLE;
      per_cnt_d = '0;
      hi_cnt_d  = '0;
      streak_d  = 4'd0;
      locked_d  = 1'b0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          per_cnt_d = '0;
          hi_cnt_d  = '0;
          if (rise) begin
            state_d   = ST_HIGH;
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
          end
        end
        ST_HIGH, ST_LOW: begin
          if (stuck_now) begin
            state_d   = ST_IDLE;
            per_cnt_d = '0;
            hi_cnt_d  = '0;
            timeout_d = 1'b1;
            stuck_d   = pwm_s_q;
            streak_d  = 4'd0;
            locked_d  = 1'b0;
          end else begin
            per_cnt_d = rise ? CNT_ONE : per_inc;
            if (state_q == ST_HIGH) begin
              hi_cnt_d = hi_inc;
              if (fall) begin
                hi_hold_d = hi_cnt_q;
                state_d   = ST_LOW;
              end
            end else if (rise) begin
              period_d    = per_cnt_q;
              high_time_d = hi_hold_q;
              valid_d     = 1'b1;
              match_d     = match_now;
              hi_cnt_d    = CNT_ONE;
              state_d     = ST_HIGH;
            end
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end
  end

  always_ff @(posedge CLK or negedge RST_N) begin
    if (!RST_N) begin
      state_q     <= ST_IDLE;
      sync1_q     <= 1'b0;
      pwm_s_q     <= 1'b0;
      pwm_d_q     <= 1'b0;
      per_cnt_q   <= '0;
      hi_cnt_q    <= '0;
      hi_hold_q   <= '0;
      period_q    <= '0;
      high_time_q <= '0;
      valid_q     <= 1'b0;
      match_q     <= 1'b0;
      locked_q    <= 1'b0;
      timeout_q   <= 1'b0;
      stuck_q     <= 1'b0;
      streak_q    <= 4'd0;
    end else begin
      state_q     <= state_d;
      sync1_q     <= sync1_d;
      pwm_s_q     <= pwm_s_d;
      pwm_d_q     <= pwm_d_d;
      per_cnt_q   <= per_cnt_d;
      hi_cnt_q    <= hi_cnt_d;
      hi_hold_q   <= hi_hold_d;
      period_q    <= period_d;
      high_time_q <= high_time_d;
      valid_q     <= valid_d;
      match_q     <= match_d;
      locked_q    <= locked_d;
      timeout_q   <= timeout_d;
      stuck_q     <= stuck_d;
      streak_q    <= streak_d;
    end
  end

  assign PERIOD      = period_q;
  assign HIGH_TIME   = high_time_q;
  assign VALID       = valid_q;
  assign MATCH       = match_q;
  assign LOCKED      = locked_q;
  assign TIMEOUT     = timeout_q;
  assign STUCK_LEVEL = stuck_q;

endmodule

// File: tb/tb_pwm_capture.sv
// tb/tb_pwm_capture.sv - scoreboard bench for pwm_capture (default instance and a 4-bit, TOL=1 instance)

module tb_pwm_capture;

  logic       clk = 1'b0;
  logic       rst_n, en_a, en_b, pwm_a, pwm_b;
  logic [7:0] period_a, high_a;
  logic [3:0] period_b, high_b;
  logic       valid_a, match_a, locked_a, timeout_a, stuck_a;
  logic       valid_b, match_b, locked_b, timeout_b, stuck_b;

  int n_tests = 0;
  int n_fail  = 0;

  typedef struct {
    bit is_to;
    int per;
    int hi;
    bit m;
    bit lvl;
  } ev_t;

  ev_t q_a[$];
  ev_t q_b[$];
  ev_t ea, eb;

  always #5 clk = ~clk;

  pwm_capture u_dut_a (
    .CLK(clk), .RST_N(rst_n), .ENABLE(en_a), .PWM_IN(pwm_a),
    .PERIOD(period_a), .HIGH_TIME(high_a), .VALID(valid_a), .MATCH(match_a),
    .LOCKED(locked_a), .TIMEOUT(timeout_a), .STUCK_LEVEL(stuck_a)
  );

  pwm_capture #(.CNT_BITS(4), .EXP_PERIOD(10), .EXP_HIGH(7), .TOL(1), .LOCK_COUNT(3)) u_dut_b (
    .CLK(clk), .RST_N(rst_n), .ENABLE(en_b), .PWM_IN(pwm_b),
    .PERIOD(period_b), .HIGH_TIME(high_b), .VALID(valid_b), .MATCH(match_b),
    .LOCKED(locked_b), .TIMEOUT(timeout_b), .STUCK_LEVEL(stuck_b)
  );

  task automatic cmp(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d, required %0d", name, act, exp);
    end
  endtask

  task automatic push_v(input int sel, input int p, input int h, input bit m);
    ev_t e;
    e.is_to = 1'b0; e.per = p; e.hi = h; e.m = m; e.lvl = 1'b0;
    if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
  endtask

  task automatic push_t(input int sel, input bit lvl);
    ev_t e;
    e.is_to = 1'b1; e.per = 0; e.hi = 0; e.m = 1'b0; e.lvl = lvl;
    if (sel == 0) q_a.push_back(e); else q_b.push_back(e);
  endtask

  task automatic drive(input int sel, input logic v);
    if (sel == 0) pwm_a = v; else pwm_b = v;
  endtask

  function automatic logic lk(input int sel);
    return (sel == 0) ? locked_a : locked_b;
  endfunction

  // One PWM period starting with a rise; optional LOCKED probes at negedge k1/k2 after the rise.
  task automatic period(input int sel, input int p, input int h,
                        input int k1, input bit e1, input int k2, input bit e2);
    drive(sel, 1'b1);
    for (int i = 1; i <= p; i++) begin
      @(negedge clk);
      if (i == k1) cmp($sformatf("locked_%0d_k%0d", sel, k1), lk(sel), e1);
      if (i == k2) cmp($sformatf("locked_%0d_k%0d", sel, k2), lk(sel), e2);
      if (i == h) drive(sel, 1'b0);
    end
  endtask

  task automatic gen(input int sel, input int p, input int h, input int n);
    repeat (n) period(sel, p, h, 0, 1'b0, 0, 1'b0);
  endtask

  always @(negedge clk) begin
    if (rst_n && (valid_a || timeout_a)) begin
      if (q_a.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL a_unexpected_event: got valid=%0d timeout=%0d, required none", valid_a, timeout_a);
      end else begin
        ea = q_a.pop_front();
        cmp("a_event_kind", {30'd0, valid_a, timeout_a}, ea.is_to ? 32'd1 : 32'd2);
        if (ea.is_to) cmp("a_stuck_level", stuck_a, ea.lvl);
        else begin
          cmp("a_period", period_a, ea.per);
          cmp("a_high_time", high_a, ea.hi);
          cmp("a_match", match_a, ea.m);
        end
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n && (valid_b || timeout_b)) begin
      if (q_b.size() == 0) begin
        n_tests++; n_fail++;
        $display("FAIL b_unexpected_event: got valid=%0d timeout=%0d, required none", valid_b, timeout_b);
      end else begin
        eb = q_b.pop_front();
        cmp("b_event_kind", {30'd0, valid_b, timeout_b}, eb.is_to ? 32'd1 : 32'd2);
        if (eb.is_to) cmp("b_stuck_level", stuck_b, eb.lvl);
        else begin
          cmp("b_period", period_b, eb.per);
          cmp("b_high_time", high_b, eb.hi);
          cmp("b_match", match_b, eb.m);
        end
      end
    end
  end

  initial begin
    rst_n = 1'b1; en_a = 1'b0; en_b = 1'b0; pwm_a = 1'b0; pwm_b = 1'b0;
    #1 rst_n = 1'b0;
    #1;
    cmp("reset_a_outputs", {period_a, high_a, valid_a, match_a, locked_a, timeout_a, stuck_a}, 0);
    cmp("reset_b_outputs", {period_b, high_b, valid_b, match_b, locked_b, timeout_b, stuck_b}, 0);
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    en_a  = 1'b1;
    @(negedge clk);

    // Nominal 10/70% train: first rise only arms, lock after the third result.
    repeat (4) push_v(0, 10, 7, 1'b1);
    gen(0, 10, 7, 3);
    cmp("a_locked_before_3rd", locked_a, 1'b0);
    period(0, 10, 7, 4, 1'b0, 5, 1'b1);
    gen(0, 10, 7, 1);

    // Shape change to 10/6 while locked.
    push_v(0, 10, 7, 1'b1);
    gen(0, 10, 6, 1);
    push_v(0, 10, 6, 1'b0);
    period(0, 10, 7, 3, 1'b1, 4, 1'b0);

    // Reset in the LOW phase.
    push_v(0, 10, 7, 1'b1);
    drive(0, 1'b1);
    repeat (7) @(negedge clk);
    drive(0, 1'b0);
    repeat (2) @(negedge clk);
    cmp("a_period_before_reset", period_a, 10);
    rst_n = 1'b0;
    #1;
    cmp("a_outputs_in_reset", {period_a, high_a, valid_a, match_a, locked_a, timeout_a, stuck_a}, 0);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    repeat (3) push_v(0, 10, 7, 1'b1);
    gen(0, 10, 7, 4);
    cmp("a_relocked", locked_a, 1'b1);

    // Enable dropped for 5 cycles while locked.
    en_a = 1'b0;
    @(negedge clk);
    cmp("a_dis_locked", locked_a, 1'b0);
    cmp("a_dis_period_held", period_a, 10);
    cmp("a_dis_high_held", high_a, 7);
    repeat (4) @(negedge clk);
    en_a = 1'b1;
    repeat (2) push_v(0, 10, 7, 1'b1);
    gen(0, 10, 7, 3);
    en_a = 1'b0;
    @(negedge clk);

    // Instance b: tolerance window of 1 cycle.
    en_b = 1'b1;
    @(negedge clk);
    gen(1, 11, 8, 1);
    push_v(1, 11, 8, 1'b1);
    gen(1, 12, 7, 1);
    push_v(1, 12, 7, 1'b0);
    repeat (3) push_v(1, 10, 7, 1'b1);
    gen(1, 10, 7, 4);
    cmp("b_locked", locked_b, 1'b1);

    // Line held high: 4-bit counter saturates and raises TIMEOUT.
    push_v(1, 10, 7, 1'b1);
    push_t(1, 1'b1);
    drive(1, 1'b1);
    for (int i = 1; i <= 22; i++) begin
      @(negedge clk);
      if (i == 17) begin
        cmp("b_locked_before_to", locked_b, 1'b1);
        cmp("b_timeout_early", timeout_b, 1'b0);
      end
      if (i == 18) begin
        cmp("b_timeout_pulse", timeout_b, 1'b1);
        cmp("b_stuck_high", stuck_b, 1'b1);
        cmp("b_locked_after_to", locked_b, 1'b0);
      end
      if (i == 19) cmp("b_timeout_one_cycle", timeout_b, 1'b0);
    end
    drive(1, 1'b0);
    repeat (3) @(negedge clk);

    // Resume, including a one-cycle high pulse.
    gen(1, 10, 7, 1);
    push_v(1, 10, 7, 1'b1);
    gen(1, 10, 1, 1);
    push_v(1, 10, 1, 1'b0);
    gen(1, 10, 7, 1);
    push_v(1, 10, 7, 1'b1);
    drive(1, 1'b1);
    repeat (5) @(negedge clk);
    en_b = 1'b0;
    drive(1, 1'b0);
    repeat (5) @(negedge clk);
    cmp("b_stuck_held", stuck_b, 1'b1);

    cmp("a_events_pending", q_a.size(), 0);
    cmp("b_events_pending", q_b.size(), 0);
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/pwm_capture.md
Name: pwm_capture

Overview:
- Measures an incoming PWM waveform: period and high time, both in CLK cycles.
- Checks each measurement against the expected shape.
- Acts as the receive/check end for the team's fixed-duty PWM generators, for example the 10-cycle/70% generator used in loopback self-test.
- Reports per-period results, a lock indication, and a stuck-line timeout.

Parameters:
- CNT_BITS, 8: width of the period and high-time counters and of the result outputs.
- EXP_PERIOD, 10: expected period in CLK cycles.
- EXP_HIGH, 7: expected high time in CLK cycles.
- TOL, 0: allowed absolute deviation, in cycles, for both period and high time.
- LOCK_COUNT, 3: consecutive matching periods required to assert LOCKED (1..15).

Ports:
- CLK  in  1  clock; all logic on the rising edge.
- RST_N  in  1  asynchronous, active-low reset.
- ENABLE  in  1  synchronous measurement enable.
- PWM_IN  in  1  PWM input; asynchronous to CLK.
- PERIOD  out  CNT_BITS  last captured period, in cycles.
- HIGH_TIME  out  CNT_BITS  last captured high time, in cycles.
- VALID  out  1  one-cycle pulse when PERIOD/HIGH_TIME update.
- MATCH  out  1  registered with VALID; 1 when both values are within TOL of expected.
- LOCKED  out  1  level; LOCK_COUNT consecutive matches seen.
- TIMEOUT  out  1  one-cycle pulse when the line is stuck.
- STUCK_LEVEL  out  1  sampled line level at the last TIMEOUT.

Behaviour:
- Reset (RST_N low, asynchronous):
  - All outputs are 0, the synchroniser is cleared, and state is IDLE.
  - Reset release is synchronous to CLK.
  - Reset mid-measurement discards the partial period; no VALID is produced.
- Input conditioning:
  - Two-flop synchroniser gives pwm_s; one further flop gives pwm_d.
  - rise = pwm_s & ~pwm_d; fall = ~pwm_s & pwm_d.
  - Edge detection lags the PWM_IN transition by 2-3 CLK cycles; measured widths are not affected.
- Counters:
  - per_cnt: on a rise, capture then load 1; otherwise increment.
  - hi_cnt: on a rise, load 1; increment while in HIGH; capture on a fall.
  - Both saturate at 2^CNT_BITS-1 and never wrap.
- FSM states:
  - IDLE:
    - Counters held at 0; fall is ignored.
    - rise -> HIGH. This first rise only starts timing; no VALID.
  - HIGH:
    - fall -> capture hi_cnt into a holding register -> LOW.
    - rise in HIGH is impossible by construction.
  - LOW:
    - rise -> PERIOD <= per_cnt, HIGH_TIME <= held high count, VALID = 1, MATCH computed -> HIGH (next period starts).
- Timeout:
  - Applies in HIGH or LOW.
  - If per_cnt is at the maximum and no edge occurs this cycle: TIMEOUT = 1, STUCK_LEVEL <= pwm_s, LOCKED <= 0, streak <= 0, -> IDLE.
  - An edge in the same cycle as saturation wins: it is processed normally, the captured value is the maximum, and no TIMEOUT is raised.
- MATCH arithmetic:
  - Unsigned absolute difference, CNT_BITS+1 bits internally.
  - MATCH = (|PERIOD-EXP_PERIOD| <= TOL) && (|HIGH_TIME-EXP_HIGH| <= TOL).
  - MATCH holds its value until the next VALID.
- Lock:
  - 4-bit streak counter; increments on VALID&MATCH, saturating at LOCK_COUNT.
  - VALID&~MATCH clears both streak and LOCKED.
  - LOCKED = 1 in the cycle after streak reaches LOCK_COUNT.
- ENABLE low:
  - Next cycle: -> IDLE, counters 0, streak 0, LOCKED 0.
  - PERIOD, HIGH_TIME and STUCK_LEVEL hold their values.
  - VALID and TIMEOUT stay 0.
  - Re-enabling requires a fresh rise to arm the measurement.
- Degenerate input: a 1-cycle high pulse is measured as HIGH_TIME = 1. Pulses shorter than one CLK may be missed; this is acceptable.

Test Plan:
- PWM_IN driven from a 10-cycle/70% generator on the same CLK, defaults -> from the 2nd rise onward, every 10 cycles: VALID, PERIOD=10, HIGH_TIME=7, MATCH=1; LOCKED rises after the 3rd VALID.
- Waveform switched to period 10/high 6 while locked -> next VALID has HIGH_TIME=6, MATCH=0; LOCKED falls the cycle after.
- TOL=1, waveforms 11/8 then 12/7 -> first gives MATCH=1, second gives MATCH=0.
- PWM_IN held high after a rise, CNT_BITS=4 -> TIMEOUT pulse 15 cycles after the rise, STUCK_LEVEL=1, LOCKED=0, no VALID; next two rises resume measurement.
- RST_N pulsed low mid-LOW phase -> all outputs 0 immediately; first rise after release gives no VALID, second gives a correct VALID.
- ENABLE dropped for 5 cycles while locked -> LOCKED=0, PERIOD/HIGH_TIME held; first VALID arrives only on the 2nd rise after re-enable.
